aes_iter_core: RTL and testbench



---
 rtl/aes_iter_core.sv | 174 +++++++++++++++++
 tb/tb_aes_iter_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES encryptor, one cipher round per clock, with the
// round key generated on the fly from a sliding key window. KEY_BITS selects
// AES-128 (Nr=10) or AES-256 (Nr=14).
// Optional feature macro: AES_KEY_REUSE_EN adds the key_reuse input and a
// stored copy of the last accepted key.
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
`ifdef AES_KEY_REUSE_EN
  input  logic                key_reuse,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam int         NK = KEY_BITS / 32;
  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t                   fsm;
  logic [0:15][7:0]       st_q;      // cipher state, byte 0 first
  logic [0:NK-1][31:0]    kw_q;      // key window, oldest word first
  logic [7:0]             rcon_q;
  logic [3:0]             rnd_q;
  logic [KEY_BITS-1:0]    key_eff;

  logic [0:15][7:0]       sb, sr, mc, st_nxt;
  logic [0:3][31:0]       nw, rk;
  logic [0:NK-1][31:0]    kw_nxt;
  logic [31:0]            tmp, sw;
  logic                   use_rot;
  logic                   last_rnd;

`ifdef AES_KEY_REUSE_EN
  logic [KEY_BITS-1:0]    key_store;

  assign key_eff = key_reuse ? key_store : in_key;

  // Remember the key actually used by each accepted block.
  always_ff @(posedge clk) begin
    if (rst)                        key_store <= '0;
    else if (in_valid && in_ready)  key_store <= key_eff;
  end
`else
  assign key_eff = in_key;
`endif

  assign in_ready = (fsm == IDLE) && !rst;
  assign last_rnd = (rnd_q == NR);

  // Round datapath: SubBytes, ShiftRows, MixColumns (not on the last round), AddRoundKey.
  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = SBOX[st_q[i]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++)
      {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} =
        mixcol({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
    st_nxt = (last_rnd ? sr : mc) ^ rk;
  end

  // Four fresh schedule words from the newest window word; Rcon rides along with RotWord.
  always_comb begin
    tmp   = kw_q[NK-1];
    sw    = subword(use_rot ? {tmp[23:0], tmp[31:24]} : tmp);
    nw[0] = kw_q[0] ^ sw ^ (use_rot ? {rcon_q, 24'h0} : 32'h0);
    for (int j = 1; j < 4; j++) nw[j] = kw_q[j] ^ nw[j-1];
  end

  if (KEY_BITS == 256) begin : g_k256
    // Round 1 consumes the second key half as-is; later rounds alternate
    // RotWord+SubWord+Rcon (even rounds) and SubWord only (odd rounds).
    assign use_rot = ~rnd_q[0];
    always_comb begin
      if (rnd_q == 4'd1) begin
        rk     = kw_q[4:7];
        kw_nxt = kw_q;
      end else begin
        rk     = nw;
        kw_nxt = {kw_q[4:7], nw};
      end
    end
  end else begin : g_k128
    assign use_rot = 1'b1;
    assign rk      = nw;
    assign kw_nxt  = nw;
  end

  // Control FSM: accept, iterate Nr rounds, hold result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      st_q      <= '0;
      kw_q      <= '0;
      rcon_q    <= 8'h01;
      rnd_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          st_q   <= in_data ^ key_eff[KEY_BITS-1 -: 128];
          kw_q   <= key_eff;
          rcon_q <= 8'h01;
          rnd_q  <= 4'd1;
          busy   <= 1'b1;
          fsm    <= ROUND;
        end
        ROUND: begin
          st_q  <= st_nxt;
          kw_q  <= kw_nxt;
          rnd_q <= rnd_q + 4'd1;
          if (use_rot) rcon_q <= xt(rcon_q);
          if (last_rnd) begin
            out_data  <= st_nxt;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            fsm       <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: drives an AES-128 and an AES-256 instance of aes_iter_core
// with directed FIPS-197 vectors and random blocks, checking against a
// behavioural AES model (full key expansion, S-box derived from GF(2^8) inverse).
module tb_aes_iter_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv0, ir0, ov0, or0, bz0;
  logic [127:0] id0, od0, ik0;
  logic         iv1, ir1, ov1, or1, bz1;
  logic [127:0] id1, od1;
  logic [255:0] ik1;
`ifdef AES_KEY_REUSE_EN
  logic         kr0, kr1;
`endif

  aes_iter_core #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .in_key(ik0),
`ifdef AES_KEY_REUSE_EN
    .key_reuse(kr0),
`endif
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .busy(bz0));

  aes_iter_core #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_key(ik1),
`ifdef AES_KEY_REUSE_EN
    .key_reuse(kr1),
`endif
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(bz1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
  endfunction

  // key is left-aligned: AES-128 uses key[255:128]
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int q = 0; q < 4; q++) t[q] = s[4*c+q];
          for (int q = 0; q < 4; q++)
            s[4*c+q] = gmul(8'h02, t[q]) ^ gmul(8'h03, t[(q+1)%4]) ^ t[(q+2)%4] ^ t[(q+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- DUT access helpers ----------------
  task automatic set_in(input bit k256, input logic v, input logic [127:0] d,
                        input logic [255:0] key, input logic reuse);
    if (k256) begin iv1 = v; id1 = d; ik1 = key; end
    else      begin iv0 = v; id0 = d; ik0 = key[255:128]; end
`ifdef AES_KEY_REUSE_EN
    if (k256) kr1 = reuse; else kr0 = reuse;
`else
    if (reuse) $display("note: key_reuse requested without AES_KEY_REUSE_EN");
`endif
  endtask

  task automatic set_iv(input bit k256, input logic v);
    if (k256) iv1 = v; else iv0 = v;
  endtask

  task automatic set_or(input bit k256, input logic v);
    if (k256) or1 = v; else or0 = v;
  endtask

  function automatic logic get_ov(input bit k256); return k256 ? ov1 : ov0; endfunction
  function automatic logic get_ir(input bit k256); return k256 ? ir1 : ir0; endfunction
  function automatic logic get_bz(input bit k256); return k256 ? bz1 : bz0; endfunction
  function automatic logic [127:0] get_od(input bit k256); return k256 ? od1 : od0; endfunction

  // One full transaction; entered and left at 1ns after a rising edge with the core idle.
  task automatic do_block(input bit k256, input logic [127:0] pt, input logic [255:0] key,
                          input logic reuse, input logic [127:0] expv, input int hold,
                          input bit tied, input string tag);
    int lat;
    int nr;
    nr = k256 ? 14 : 10;
    set_in(k256, 1'b1, pt, key, reuse);
    set_or(k256, tied);
    chk({tag, "/in_ready_before"}, 128'(get_ir(k256)), 128'd1);
    @(posedge clk); #1;                       // accept edge
    set_in(k256, 1'b0, {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
    chk({tag, "/busy"}, 128'(get_bz(k256)), 128'd1);
    lat = 0;
    while (!get_ov(k256) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 128'(lat), 128'(nr));
    chk({tag, "/data"}, get_od(k256), expv);
    chk({tag, "/in_ready_pending"}, 128'(get_ir(k256)), 128'd0);
    for (int h = 0; h < hold; h++) begin
      set_iv(k256, 1'($urandom % 2));
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 128'(get_ov(k256)), 128'd1);
      chk({tag, "/hold_data"}, get_od(k256), expv);
      chk({tag, "/hold_in_ready"}, 128'(get_ir(k256)), 128'd0);
    end
    set_iv(k256, 1'b0);
    set_or(k256, 1'b1);
    @(posedge clk); #1;                       // output handshake edge
    set_or(k256, 1'b0);
    chk({tag, "/out_valid_after"}, 128'(get_ov(k256)), 128'd0);
    chk({tag, "/in_ready_after"}, 128'(get_ir(k256)), 128'd1);
  endtask

  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY2 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] expv;
    logic         seen_ov;
    bit           k256, tied;

    rst = 1'b1;
    iv0 = 1'b0; id0 = '0; ik0 = '0; or0 = 1'b0;
    iv1 = 1'b0; id1 = '0; ik1 = '0; or1 = 1'b0;
`ifdef AES_KEY_REUSE_EN
    kr0 = 1'b0; kr1 = 1'b0;
`endif
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset/in_ready", 128'(ir0), 128'd0);
    chk("reset/out_valid", 128'(ov0), 128'd0);
    chk("reset/busy", 128'(bz0), 128'd0);
    chk("reset/out_data", od0, 128'd0);
    chk("reset/out_valid256", 128'(ov1), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset/in_ready_after", 128'(ir0), 128'd1);
    chk("reset/in_ready_after256", 128'(ir1), 128'd1);

    // FIPS vectors, first one under 20 cycles of backpressure with in_valid pulses
    do_block(1'b0, PT1, KEY1, 1'b0, CT1, 20, 1'b0, "fips128_a");
    do_block(1'b0, PT2, KEY2, 1'b0, CT2, 0, 1'b0, "fips128_b");
    do_block(1'b1, PT2, KEY3, 1'b0, CT3, 2, 1'b0, "fips256");

    // back-to-back with out_ready tied high
    do_block(1'b0, PT1, KEY1, 1'b0, CT1, 0, 1'b1, "b2b_1");
    do_block(1'b0, PT2, KEY2, 1'b0, CT2, 0, 1'b1, "b2b_2");

    // reset during round 5, with in_valid offered on the reset edge
    set_in(1'b0, 1'b1, PT1, KEY1, 1'b0);
    @(posedge clk); #1;
    set_iv(1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    set_iv(1'b0, 1'b1);
    @(posedge clk); #1;
    chk("midrst/out_valid", 128'(ov0), 128'd0);
    chk("midrst/busy", 128'(bz0), 128'd0);
    chk("midrst/out_data", od0, 128'd0);
    chk("midrst/in_ready_in_rst", 128'(ir0), 128'd0);
    rst = 1'b0;
    set_iv(1'b0, 1'b0);
    #1;
    chk("midrst/in_ready", 128'(ir0), 128'd1);
    seen_ov = 1'b0;
    repeat (16) begin @(posedge clk); #1; seen_ov = seen_ov | ov0 | bz0; end
    chk("midrst/no_output", 128'(seen_ov), 128'd0);

`ifdef AES_KEY_REUSE_EN
    // first accept after reset with key_reuse: all-zero key
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_block(1'b1, pt, key, 1'b1, aes_model(pt, 256'h0, 8), 0, 1'b0, "reuse_zero256");
`endif
    do_block(1'b0, PT1, KEY1, 1'b0, CT1, 0, 1'b0, "postrst_fips");
`ifdef AES_KEY_REUSE_EN
    do_block(1'b0, PT2, 256'h0, 1'b1, 128'h8df4e9aac5c7573a27d8d055d6e4d64b, 0, 1'b0, "reuse128");
`endif

    // random blocks against the model
    for (int i = 0; i < 12; i++) begin
      k256 = bit'(i % 2);
      tied = bit'($urandom % 2);
      pt   = {$urandom, $urandom, $urandom, $urandom};
      key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (!k256) key[127:0] = '0;
      expv = aes_model(pt, key, k256 ? 8 : 4);
      do_block(k256, pt, key, 1'b0, expv, tied ? 0 : int'($urandom % 4), tied,
               k256 ? "rand256" : "rand128");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
